// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared types and constants for the nonce dispatcher
package miner_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        EXHAUSTED,
        DONE
    } state_t;

    localparam int          NONCE_W   = 32;
    localparam logic [31:0] NONCE_MAX = 32'hFFFF_FFFF;

    // Index width for an n-entry vector, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nonce_dispatcher_if.sv
// rtl/nonce_dispatcher_if.sv - host/core-array signals of the nonce dispatcher
interface nonce_dispatcher_if #(
    parameter int NUM_CORES = 4
) ();
    import miner_pkg::*;

    localparam int ID_W = id_width(NUM_CORES);

    logic                 new_job;
    logic [NUM_CORES-1:0] req;
    logic [NUM_CORES-1:0] found;
    logic [NUM_CORES-1:0] grant;
    logic [NONCE_W-1:0]   grant_nonce;
    logic                 busy;
    logic                 done;
    logic [ID_W-1:0]      winner_id;
    logic                 exhausted;

    modport master (
        input  new_job, req, found,
        output grant, grant_nonce, busy, done, winner_id, exhausted
    );

    modport slave (
        output new_job, req, found,
        input  grant, grant_nonce, busy, done, winner_id, exhausted
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first requester at or after ptr
module rr_arbiter
    import miner_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    function automatic int wrap_add(input int p, input int off);
        int s;
        s = p + off;
        if (s >= N) s = s - N;
        return s;
    endfunction

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = IW'(wrap_add(int'(ptr), i));
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/nonce_dispatcher.sv
// rtl/nonce_dispatcher.sv - round-robin nonce dispatch to hash cores with job restart, found and exhaustion handling
module nonce_dispatcher
    import miner_pkg::*;
#(
    parameter int          NUM_CORES = 4,
    parameter logic [31:0] START_VAL = 32'h0
) (
    input  logic               clk,
    input  logic               n_rst,
    nonce_dispatcher_if.master bus
);

    localparam int ID_W = id_width(NUM_CORES);

    state_t               state_q, state_n;
    logic [NONCE_W-1:0]   counter_q, counter_n;
    logic [ID_W-1:0]      ptr_q, ptr_n;
    logic [NUM_CORES-1:0] grant_q, grant_n;
    logic [NONCE_W-1:0]   nonce_q, nonce_n;
    logic [ID_W-1:0]      winner_q, winner_n;

    logic [NUM_CORES-1:0] arb_grant;
    logic [ID_W-1:0]      arb_idx;
    logic [ID_W-1:0]      found_idx;

    rr_arbiter #(
        .N  (NUM_CORES),
        .IW (ID_W)
    ) u_arb (
        .req   (bus.req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_comb begin
        found_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (bus.found[i]) found_idx = ID_W'(i);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            counter_q <= START_VAL;
            ptr_q     <= '0;
            grant_q   <= '0;
            nonce_q   <= '0;
            winner_q  <= '0;
        end else begin
            state_q   <= state_n;
            counter_q <= counter_n;
            ptr_q     <= ptr_n;
            grant_q   <= grant_n;
            nonce_q   <= nonce_n;
            winner_q  <= winner_n;
        end
    end

    // new_job overrides everything else, including found and a pending grant.
    always_comb begin
        state_n   = state_q;
        counter_n = counter_q;
        ptr_n     = ptr_q;
        grant_n   = '0;
        nonce_n   = nonce_q;
        winner_n  = winner_q;
        if (bus.new_job) begin
            state_n   = DISPATCH;
            counter_n = START_VAL;
            ptr_n     = '0;
            winner_n  = '0;
        end else begin
            case (state_q)
                DISPATCH: begin
                    if (bus.found != '0) begin
                        state_n  = DONE;
                        winner_n = found_idx;
                    end else if (bus.req != '0) begin
                        grant_n   = arb_grant;
                        nonce_n   = counter_q;
                        counter_n = counter_q + 32'd1;
                        ptr_n     = (arb_idx == ID_W'(NUM_CORES - 1)) ? '0 : arb_idx + 1'b1;
                        if (counter_q == NONCE_MAX) state_n = EXHAUSTED;
                    end
                end
                EXHAUSTED: begin
                    if (bus.found != '0) begin
                        state_n  = DONE;
                        winner_n = found_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_nonce = nonce_q;
    assign bus.busy        = (state_q == DISPATCH);
    assign bus.done        = (state_q == DONE);
    assign bus.exhausted   = (state_q == EXHAUSTED);
    assign bus.winner_id   = winner_q;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// tb/tb_nonce_dispatcher.sv - directed self-checking bench for nonce_dispatcher
module tb_nonce_dispatcher;

    logic clk;
    logic n_rst;

    int errors;
    int checks;

    nonce_dispatcher_if #(.NUM_CORES(4)) bus_a ();
    nonce_dispatcher_if #(.NUM_CORES(4)) bus_h ();

    nonce_dispatcher #(
        .NUM_CORES (4),
        .START_VAL (32'h0)
    ) u_dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_a)
    );

    nonce_dispatcher #(
        .NUM_CORES (4),
        .START_VAL (32'hFFFF_FFFE)
    ) u_dut_hi (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  exp_g [5];
    logic [31:0] exp_n [5];

    initial begin
        errors = 0;
        checks = 0;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        for (int i = 0; i < 5; i++) exp_n[i] = 32'(i);

        n_rst = 1'b0;
        bus_a.new_job = 1'b0; bus_a.req = '0; bus_a.found = '0;
        bus_h.new_job = 1'b0; bus_h.req = '0; bus_h.found = '0;
        #2;
        check("rst_grant", 32'(bus_a.grant), 32'h0);
        check("rst_nonce", bus_a.grant_nonce, 32'h0);
        check("rst_busy", 32'(bus_a.busy), 32'h0);
        check("rst_done", 32'(bus_a.done), 32'h0);
        check("rst_winner", 32'(bus_a.winner_id), 32'h0);
        check("rst_exh", 32'(bus_a.exhausted), 32'h0);
        cyc();
        n_rst = 1'b1;

        // Single requester: IDLE ignores it until new_job
        bus_a.req = 4'b0001;
        cyc();
        check("idle_grant", 32'(bus_a.grant), 32'h0);
        check("idle_busy", 32'(bus_a.busy), 32'h0);
        bus_a.new_job = 1'b1;
        cyc();
        check("job_busy", 32'(bus_a.busy), 32'h1);
        check("job_nogrant", 32'(bus_a.grant), 32'h0);
        bus_a.new_job = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("c0_grant", 32'(bus_a.grant), 32'h1);
            check("c0_nonce", bus_a.grant_nonce, 32'(i));
        end

        // All four requesting: rotate 0,1,2,3,0
        bus_a.req = 4'b1111;
        bus_a.new_job = 1'b1;
        cyc();
        check("rr_job_nogrant", 32'(bus_a.grant), 32'h0);
        bus_a.new_job = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("rr_grant", 32'(bus_a.grant), 32'(exp_g[i]));
            check("rr_nonce", bus_a.grant_nonce, exp_n[i]);
        end

        // found wins over pending requests; winner is lowest index
        bus_a.found = 4'b1010;
        cyc();
        check("fnd_nogrant", 32'(bus_a.grant), 32'h0);
        check("fnd_done", 32'(bus_a.done), 32'h1);
        check("fnd_busy", 32'(bus_a.busy), 32'h0);
        check("fnd_winner", 32'(bus_a.winner_id), 32'h1);
        bus_a.found = 4'b0001;
        cyc();
        check("fnd2_winner", 32'(bus_a.winner_id), 32'h1);
        check("fnd2_done", 32'(bus_a.done), 32'h1);
        check("done_nogrant", 32'(bus_a.grant), 32'h0);

        // new_job beats found from DONE
        bus_a.new_job = 1'b1;
        bus_a.found = 4'b0100;
        bus_a.req = 4'b0001;
        cyc();
        check("rj_busy", 32'(bus_a.busy), 32'h1);
        check("rj_done", 32'(bus_a.done), 32'h0);
        check("rj_winner", 32'(bus_a.winner_id), 32'h0);
        check("rj_nogrant", 32'(bus_a.grant), 32'h0);
        bus_a.new_job = 1'b0;
        bus_a.found = '0;
        cyc();
        check("rj_grant", 32'(bus_a.grant), 32'h1);
        check("rj_nonce", bus_a.grant_nonce, 32'h0);

        // Asynchronous reset with a grant showing
        cyc();
        check("pre_rst_grant", 32'(bus_a.grant), 32'h1);
        check("pre_rst_nonce", bus_a.grant_nonce, 32'h1);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_grant", 32'(bus_a.grant), 32'h0);
        check("arst_nonce", bus_a.grant_nonce, 32'h0);
        check("arst_busy", 32'(bus_a.busy), 32'h0);
        @(negedge clk);
        n_rst = 1'b1;
        cyc();
        cyc();
        check("post_rst_grant", 32'(bus_a.grant), 32'h0);
        check("post_rst_busy", 32'(bus_a.busy), 32'h0);
        bus_a.req = '0;

        // Exhaustion at the top of the nonce space
        bus_h.req = 4'b0011;
        bus_h.new_job = 1'b1;
        cyc();
        check("hi_nogrant", 32'(bus_h.grant), 32'h0);
        bus_h.new_job = 1'b0;
        cyc();
        check("hi_g0", 32'(bus_h.grant), 32'h1);
        check("hi_n0", bus_h.grant_nonce, 32'hFFFF_FFFE);
        check("hi_exh0", 32'(bus_h.exhausted), 32'h0);
        cyc();
        check("hi_g1", 32'(bus_h.grant), 32'h2);
        check("hi_n1", bus_h.grant_nonce, 32'hFFFF_FFFF);
        check("hi_exh1", 32'(bus_h.exhausted), 32'h1);
        cyc();
        check("exh_nogrant", 32'(bus_h.grant), 32'h0);
        check("exh_hold", 32'(bus_h.exhausted), 32'h1);
        bus_h.found = 4'b0010;
        cyc();
        check("exh_done", 32'(bus_h.done), 32'h1);
        check("exh_winner", 32'(bus_h.winner_id), 32'h1);
        check("exh_clear", 32'(bus_h.exhausted), 32'h0);
        bus_h.found = '0;
        bus_h.req = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
